// File: rtl/wordline_sequencer.sv
// Registered row sequencer: per row a PRE_CYC precharge phase then a PULSE_CYC one-hot wordline pulse.
// Accept-to-first-precharge latency is 1 cycle; req is ignored (not queued) while busy; ready only in IDLE.
module wordline_sequencer #(
  parameter int ADR_W     = 3,
  parameter int PRE_CYC   = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADR_W-1:0]      adr,
  input  logic [ADR_W-1:0]      burst,
  input  logic                  we,
  output logic                  ready,
  output logic                  pre,
  output logic [2**ADR_W-1:0]   sel_x,
  output logic                  wen,
  output logic [ADR_W-1:0]      cur_adr,
  output logic                  done
);

  localparam int ROWS  = 2**ADR_W;
  localparam int MAXC  = (PRE_CYC > PULSE_CYC) ? PRE_CYC : PULSE_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [ROWS-1:0]  ONE_ROW  = ROWS'(1);

  typedef enum logic [1:0] {IDLE, PRE, WL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADR_W-1:0]  rem_q, rem_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic              we_q, we_d;
  logic              pre_q, pre_d;
  logic [ROWS-1:0]   sel_q, sel_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      pre_q   <= 1'b0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    adr_d   = adr_q;
    we_d    = we_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = PRE;
          cnt_d   = '0;
          adr_d   = adr;
          rem_d   = burst;
          we_d    = we;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = WL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WL: begin
        if (cnt_q == PUL_LAST) begin
          cnt_d = '0;
          if (rem_q != '0) begin
            state_d = PRE;
            adr_d   = adr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so every array-facing signal leaves a flop.
    pre_d = (state_d == PRE);
    sel_d = (state_d == WL) ? (ONE_ROW << adr_d) : '0;
    wen_d = (state_d == WL) && we_d;
  end

  assign ready   = (state_q == IDLE);
  assign pre     = pre_q;
  assign sel_x   = sel_q;
  assign wen     = wen_q;
  assign cur_adr = adr_q;
  assign done    = done_q;

endmodule

// File: tb/tb_wordline_sequencer.sv
// Bench for wordline_sequencer: default instance (3/1/2) and a wide instance (4/2/3) against a row/cycle model.
module tb_wordline_sequencer;

  logic        clk;
  logic        rst_n;

  logic        req_a, we_a;
  logic [2:0]  adr_a, burst_a;
  logic        ready_a, pre_a, wen_a, done_a;
  logic [7:0]  sel_a;
  logic [2:0]  cur_a;

  logic        req_b, we_b;
  logic [3:0]  adr_b, burst_b;
  logic        ready_b, pre_b, wen_b, done_b;
  logic [15:0] sel_b;
  logic [3:0]  cur_b;

  int tests;
  int fails;

  wordline_sequencer #(.ADR_W(3), .PRE_CYC(1), .PULSE_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .adr(adr_a), .burst(burst_a), .we(we_a),
    .ready(ready_a), .pre(pre_a), .sel_x(sel_a), .wen(wen_a), .cur_adr(cur_a), .done(done_a)
  );

  wordline_sequencer #(.ADR_W(4), .PRE_CYC(2), .PULSE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .adr(adr_b), .burst(burst_b), .we(we_b),
    .ready(ready_b), .pre(pre_b), .sel_x(sel_b), .wen(wen_b), .cur_adr(cur_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input bit rq, input int a, input int b, input bit w);
    if (inst == 0) begin
      req_a = rq; adr_a = 3'(a); burst_a = 3'(b); we_a = w;
    end else begin
      req_b = rq; adr_b = 4'(a); burst_b = 4'(b); we_b = w;
    end
  endtask

  task automatic drive_junk(input int inst, input bit rq);
    drive(inst, rq, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic read(input int inst, output logic p, output logic [15:0] s, output logic w,
                      output logic [15:0] c, output logic d, output logic r);
    if (inst == 0) begin
      p = pre_a; s = {8'h00, sel_a}; w = wen_a; c = {13'h0, cur_a}; d = done_a; r = ready_a;
    end else begin
      p = pre_b; s = sel_b; w = wen_b; c = {12'h0, cur_b}; d = done_b; r = ready_b;
    end
  endtask

  task automatic check_all(input int inst, input string tag, input logic ep, input logic [15:0] es,
                           input logic ew, input int ec, input logic ed, input logic er);
    logic p, w, d, r;
    logic [15:0] s, c;
    read(inst, p, s, w, c, d, r);
    check({tag, ".pre"},   {15'h0, p}, {15'h0, ep});
    check({tag, ".sel"},   s, es);
    check({tag, ".wen"},   {15'h0, w}, {15'h0, ew});
    check({tag, ".cur"},   c, 16'(ec));
    check({tag, ".done"},  {15'h0, d}, {15'h0, ed});
    check({tag, ".ready"}, {15'h0, r}, {15'h0, er});
  endtask

  // Called at posedge+1 of a cycle where the instance is ready; returns in the done cycle.
  task automatic do_txn(input int inst, input string tag, input int a, input int b, input bit w, input bit hold);
    int rows, pc, wc, row;
    logic p, wn, d, r;
    logic [15:0] s, c;
    rows = (inst == 0) ? 8 : 16;
    pc   = (inst == 0) ? 1 : 2;
    wc   = (inst == 0) ? 2 : 3;
    drive(inst, 1'b1, a, b, w);
    read(inst, p, s, wn, c, d, r);
    check({tag, ".accept_ready"}, {15'h0, r}, 16'h1);
    @(posedge clk); #1;
    for (int k = 0; k <= b; k++) begin
      row = (a + k) % rows;
      for (int i = 0; i < pc; i++) begin
        drive_junk(inst, hold);
        check_all(inst, {tag, ".pre_ph"}, 1'b1, 16'h0, 1'b0, row, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
      for (int i = 0; i < wc; i++) begin
        drive_junk(inst, hold);
        check_all(inst, {tag, ".wl_ph"}, 1'b0, 16'(1) << row, w, row, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
    end
    check_all(inst, {tag, ".done_cyc"}, 1'b0, 16'h0, 1'b0, (a + b) % rows, 1'b1, 1'b1);
    if (!hold) drive_junk(inst, 1'b0);
  endtask

  task automatic idle_cycle(input int inst, input string tag, input int exp_cur);
    drive_junk(inst, 1'b0);
    @(posedge clk); #1;
    check_all(inst, tag, 1'b0, 16'h0, 1'b0, exp_cur, 1'b0, 1'b1);
  endtask

  initial begin
    int a, b;
    bit w, h;
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_junk(0, 1'b1);
      drive_junk(1, 1'b1);
      @(posedge clk); #1;
      check_all(0, "rst_a", 1'b0, 16'h0, 1'b0, 0, 1'b0, 1'b1);
      check_all(1, "rst_b", 1'b0, 16'h0, 1'b0, 0, 1'b0, 1'b1);
    end
    drive_junk(0, 1'b0);
    drive_junk(1, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(0, "post_rst_a", 1'b0, 16'h0, 1'b0, 0, 1'b0, 1'b1);
    idle_cycle(1, "post_rst_b", 0);

    do_txn(0, "single", 5, 0, 1'b0, 1'b0);
    idle_cycle(0, "single_idle", 5);
    do_txn(0, "wrap", 6, 3, 1'b0, 1'b0);
    idle_cycle(0, "wrap_idle", 1);
    do_txn(0, "write", 0, 0, 1'b1, 1'b0);
    idle_cycle(0, "write_idle", 0);
    do_txn(0, "held1", 2, 1, 1'b1, 1'b1);
    do_txn(0, "held2", 7, 0, 1'b0, 1'b1);
    idle_cycle(0, "held_idle", 7);
    do_txn(1, "wide", 15, 1, 1'b0, 1'b0);
    idle_cycle(1, "wide_idle", 0);

    for (int t = 0; t < 6; t++) begin
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      do_txn(0, "rnd_a", a, b, w, h);
    end
    idle_cycle(0, "rnd_a_idle", (a + b) % 8);
    for (int t = 0; t < 3; t++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 4));
      w = 1'($urandom_range(0, 1));
      do_txn(1, "rnd_b", a, b, w, 1'b0);
    end
    idle_cycle(1, "rnd_b_idle", (a + b) % 16);

    // Reset dropped during the second wordline cycle must clear the row drive asynchronously.
    drive(0, 1'b1, 3, 0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0, 1'b0);
    check_all(0, "mid_pre", 1'b1, 16'h0, 1'b0, 3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all(0, "mid_wl1", 1'b0, 16'h8, 1'b1, 3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all(0, "mid_wl2", 1'b0, 16'h8, 1'b1, 3, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_all(0, "async_clr", 1'b0, 16'h0, 1'b0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_all(0, "in_rst", 1'b0, 16'h0, 1'b0, 0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    idle_cycle(0, "rel1", 0);
    idle_cycle(0, "rel2", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
